// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU between two requesters. Requests
//   are granted round-robin in IDLE. The winner's operands are registered
//   onto the alu_* outputs. The ALU outputs are captured in EXEC, and the
//   response is held in RESP until the owner accepts it.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   req{0,1}_valid/_ready         request handshake per requester
//   req{0,1}_fn/_btype/_bneq      function code and branch qualifiers
//   req{0,1}_opa/_opb             operands
//   rsp{0,1}_valid/_ready         response handshake per requester
//   rsp_result, rsp_btaken        captured ALU outputs (shared by both ports)
//   alu_fn/_btype/_bneq/_opa/_opb registered operation driven to the ALU
//   alu_result, alu_btaken        combinational ALU outputs
//   busy                          high whenever the FSM is not in IDLE
module alu_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned FNW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [FNW-1:0]  req0_fn,
  input  logic            req0_btype,
  input  logic            req0_bneq,
  input  logic [XLEN-1:0] req0_opa,
  input  logic [XLEN-1:0] req0_opb,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [FNW-1:0]  req1_fn,
  input  logic            req1_btype,
  input  logic            req1_bneq,
  input  logic [XLEN-1:0] req1_opa,
  input  logic [XLEN-1:0] req1_opb,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_btaken,
  output logic [FNW-1:0]  alu_fn,
  output logic            alu_btype,
  output logic            alu_bneq,
  output logic [XLEN-1:0] alu_opa,
  output logic [XLEN-1:0] alu_opb,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_btaken,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nx;
  logic   owner;       // requester that owns the in-flight operation
  logic   last_grant;  // requester granted most recently
  logic   grant0, grant1;

  // On a tie, the port that was not granted last wins. last_grant resets
  // to 1, so port 0 wins the first tie.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if (owner ? rsp1_ready : rsp0_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_fn     <= '0;
      alu_btype  <= 1'b0;
      alu_bneq   <= 1'b0;
      alu_opa    <= '0;
      alu_opb    <= '0;
      rsp_result <= '0;
      rsp_btaken <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (grant0 || grant1)) begin
        owner      <= grant1;
        last_grant <= grant1;
        if (grant1) begin
          alu_fn    <= req1_fn;
          alu_btype <= req1_btype;
          alu_bneq  <= req1_bneq;
          alu_opa   <= req1_opa;
          alu_opb   <= req1_opb;
        end else begin
          alu_fn    <= req0_fn;
          alu_btype <= req0_btype;
          alu_bneq  <= req0_bneq;
          alu_opa   <= req0_opa;
          alu_opb   <= req0_opb;
        end
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_btaken <= alu_btaken;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter. A small ALU stub closes the alu_* loop.
//   Single operations are driven from a vector table. Contention,
//   backpressure, mid-operation reset and held requests are hand-written
//   sequences. Inputs change on the falling edge, and outputs are sampled
//   on the falling edge or shortly after it.
module tb_alu_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned FNW  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [FNW-1:0]  req_fn [2];
  logic [1:0]      req_btype = '0;
  logic [1:0]      req_bneq = '0;
  logic [XLEN-1:0] req_opa [2];
  logic [XLEN-1:0] req_opb [2];
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready = '0;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_btaken;
  logic [FNW-1:0]  alu_fn;
  logic            alu_btype, alu_bneq;
  logic [XLEN-1:0] alu_opa, alu_opb;
  logic [XLEN-1:0] alu_result;
  logic            alu_btaken;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ALU stub: 0 add, 8 sub, 7 and, 6 or, 4 xor, other codes give 0.
  // A branch is taken on equal (bneq=0) or on not-equal (bneq=1).
  always_comb begin
    case (alu_fn)
      4'h0:    alu_result = alu_opa + alu_opb;
      4'h8:    alu_result = alu_opa - alu_opb;
      4'h7:    alu_result = alu_opa & alu_opb;
      4'h6:    alu_result = alu_opa | alu_opb;
      4'h4:    alu_result = alu_opa ^ alu_opb;
      default: alu_result = '0;
    endcase
    alu_btaken = alu_btype && (alu_bneq ? (alu_opa != alu_opb) : (alu_opa == alu_opb));
  end

  alu_arbiter #(.XLEN(XLEN), .FNW(FNW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_fn(req_fn[0]),
    .req0_btype(req_btype[0]), .req0_bneq(req_bneq[0]),
    .req0_opa(req_opa[0]), .req0_opb(req_opb[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_fn(req_fn[1]),
    .req1_btype(req_btype[1]), .req1_bneq(req_bneq[1]),
    .req1_opa(req_opa[1]), .req1_opb(req_opb[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
    .rsp_result(rsp_result), .rsp_btaken(rsp_btaken),
    .alu_fn(alu_fn), .alu_btype(alu_btype), .alu_bneq(alu_bneq),
    .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_result(alu_result), .alu_btaken(alu_btaken),
    .busy(busy)
  );

  typedef struct {
    logic            port;
    logic [FNW-1:0]  fn;
    logic            btype;
    logic            bneq;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] res;
    logic            bt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic p, input logic [FNW-1:0] fn, input logic bt,
                         input logic bn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_fn[p] = fn; req_btype[p] = bt; req_bneq[p] = bn;
    req_opa[p] = a; req_opb[p] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Single isolated operation with rsp_ready already high.
  task automatic do_op(input vec_t v);
    logic [1:0] oh;
    oh = v.port ? 2'b10 : 2'b01;
    @(negedge clk);
    set_req(v.port, v.fn, v.btype, v.bneq, v.opa, v.opb);
    req_valid[v.port] = 1'b1;
    rsp_ready[v.port] = 1'b1;
    #1;
    check("op_req_ready", {30'd0, req_ready}, {30'd0, oh});
    check("op_busy_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);                       // EXEC
    req_valid[v.port] = 1'b0;
    check("op_busy_exec", {31'd0, busy}, 32'd1);
    check("op_alu_opa", alu_opa, v.opa);
    check("op_alu_opb", alu_opb, v.opb);
    check("op_alu_ctl", {26'd0, alu_fn, alu_btype, alu_bneq}, {26'd0, v.fn, v.btype, v.bneq});
    check("op_rsp_valid_exec", {30'd0, rsp_valid}, 32'd0);
    @(negedge clk);                       // RESP
    check("op_rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
    check("op_result", rsp_result, v.res);
    check("op_btaken", {31'd0, rsp_btaken}, {31'd0, v.bt});
    check("op_busy_resp", {31'd0, busy}, 32'd1);
    @(negedge clk);                       // back to IDLE
    check("op_busy_done", {31'd0, busy}, 32'd0);
    check("op_rsp_valid_done", {30'd0, rsp_valid}, 32'd0);
    rsp_ready[v.port] = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'h0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0};
    vecs[1] = '{1'b1, 4'h8, 1'b1, 1'b1, 32'd3, 32'd3, 32'd0, 1'b0};
    vecs[2] = '{1'b1, 4'h8, 1'b1, 1'b1, 32'd3, 32'd4, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{1'b0, 4'h8, 1'b1, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1};
    vecs[4] = '{1'b1, 4'h7, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0};
    vecs[5] = '{1'b0, 4'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
    vecs[6] = '{1'b1, 4'hF, 1'b0, 1'b1, 32'd6, 32'd2, 32'd0, 1'b0};
    for (int p = 0; p < 2; p++) set_req(p[0], '0, 1'b0, 1'b0, '0, '0);

    // Reset state
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_btaken", {31'd0, rsp_btaken}, 32'd0);
    check("rst_alu", alu_opa | alu_opb | {28'd0, alu_fn} | {31'd0, alu_btype | alu_bneq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single operations
    for (int i = 0; i < 7; i++) do_op(vecs[i]);

    // Contention: both held valid; after reset the order is 0,1,0,1
    do_reset();
    @(negedge clk);
    set_req(1'b0, 4'h0, 1'b0, 1'b0, 32'd10, 32'd1);
    set_req(1'b1, 4'h0, 1'b0, 1'b0, 32'd20, 32'd2);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_oh;
      exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      check("cont_grant", {30'd0, req_ready}, {30'd0, exp_oh});
      @(negedge clk);
      check("cont_ready_exec", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("cont_rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_oh});
      check("cont_result", rsp_result, (i % 2 == 0) ? 32'd11 : 32'd22);
      @(negedge clk);
      if (i == 3) req_valid = 2'b00;
      #1;
    end
    @(negedge clk);
    check("cont_idle_after", {31'd0, busy}, 32'd0);
    rsp_ready = 2'b00;

    // Backpressure on rsp0 with a pending req1
    @(negedge clk);
    set_req(1'b0, 4'h0, 1'b0, 1'b0, 32'd100, 32'd23);
    req_valid[0] = 1'b1;
    #1;
    check("bp_req0_ready", {30'd0, req_ready}, 32'd1);
    @(negedge clk);                       // EXEC
    req_valid[0] = 1'b0;
    set_req(1'b1, 4'h0, 1'b0, 1'b0, 32'd7, 32'd8);
    req_valid[1] = 1'b1;
    #1;
    check("bp_ready_exec", {30'd0, req_ready}, 32'd0);
    @(negedge clk);                       // RESP
    check("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check("bp_result", rsp_result, 32'd123);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {30'd0, rsp_valid}, 32'd1);
      check("bp_hold_result", rsp_result, 32'd123);
      check("bp_hold_busy", {31'd0, busy}, 32'd1);
      check("bp_hold_ready", {30'd0, req_ready}, 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);                       // IDLE after rsp0 handshake
    rsp_ready[0] = 1'b0;
    check("bp_rsp_cleared", {30'd0, rsp_valid}, 32'd0);
    check("bp_req1_ready", {30'd0, req_ready}, 32'd2);
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("bp_rsp1_valid", {30'd0, rsp_valid}, 32'd2);
    check("bp_rsp1_result", rsp_result, 32'd15);
    @(negedge clk);
    rsp_ready[1] = 1'b0;

    // Reset during EXEC
    @(negedge clk);
    set_req(1'b0, 4'h0, 1'b0, 1'b0, 32'd1, 32'd2);
    req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    @(negedge clk);                       // EXEC
    req_valid[0] = 1'b0;
    check("mid_busy_exec", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_alu_opa", alu_opa, 32'd0);
    @(negedge clk);
    check("mid_result", rsp_result, 32'd0);
    rst = 1'b0;
    rsp_ready[0] = 1'b0;
    do_op('{1'b0, 4'h0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 1'b0});

    // Held req1 during port-0 operation, operands stable
    @(negedge clk);
    set_req(1'b0, 4'h4, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_000F);
    req_valid[0] = 1'b1;
    rsp_ready = 2'b11;
    @(negedge clk);                       // EXEC of port 0
    req_valid[0] = 1'b0;
    set_req(1'b1, 4'h8, 1'b0, 1'b0, 32'd40, 32'd2);
    req_valid[1] = 1'b1;
    #1;
    check("held_ready_exec", {30'd0, req_ready}, 32'd0);
    @(negedge clk);                       // RESP of port 0
    check("held_rsp0", {30'd0, rsp_valid}, 32'd1);
    check("held_rsp0_result", rsp_result, 32'h0000_00F0);
    check("held_ready_resp", {30'd0, req_ready}, 32'd0);
    @(negedge clk);                       // first IDLE
    check("held_req1_ready", {30'd0, req_ready}, 32'd2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("held_rsp1", {30'd0, rsp_valid}, 32'd2);
    check("held_rsp1_result", rsp_result, 32'd38);
    @(negedge clk);
    check("held_idle", {31'd0, busy}, 32'd0);
    rsp_ready = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequential arbiter that shares one combinational ALU instance between two requesters, e.g. integer execute and address-generation/debug. Each requester issues operations over a valid/ready request channel and gets result and branch outcome over a valid/ready response channel. The block registers operands into the ALU, captures its outputs, and grants round-robin. It sits between the issue logic and the ALU; the ALU itself is instantiated outside and wired to the `alu_*` ports.

## Interface
- XLEN, 32, operand/result width
- FNW, 4, ALU function-code width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- reqN_valid  in  1  (N = 0,1) request N valid
- reqN_ready  out  1  request N accepted this cycle
- reqN_fn  in  FNW  ALU function code
- reqN_btype  in  1  branch-type operation
- reqN_bneq  in  1  branch-not-equal qualifier
- reqN_opa, reqN_opb  in  XLEN  operands A, B
- rspN_valid  out  1  response for requester N valid
- rspN_ready  in  1  requester N consumes response
- rsp_result  out  XLEN  captured ALU result (shared)
- rsp_btaken  out  1  captured branch-taken (shared)
- alu_fn  out  FNW  to ALU
- alu_btype, alu_bneq  out  1  to ALU
- alu_opa, alu_opb  out  XLEN  to ALU
- alu_result  in  XLEN  from ALU
- alu_btaken  in  1  from ALU
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if no reqN_valid, stay. Otherwise grant one requester:
  - only one valid: grant it.
  - both valid: grant the requester not equal to `last_grant`.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- On grant:
  - reqN_ready = 1 combinationally for the winner only, and only in IDLE.
  - Latch fn/btype/bneq/opa/opb into the alu_* registers.
  - Record the owner; set last_grant = owner; go to EXEC.
- EXEC: ALU evaluates the registered operands combinationally. Capture alu_result into rsp_result and alu_btaken into rsp_btaken. Set rsp<owner>_valid; go to RESP.
- RESP: hold rsp<owner>_valid, rsp_result and rsp_btaken stable until rsp<owner>_ready = 1. On that edge, clear valid and return to IDLE.
- The non-owner rspN_valid is always 0. reqN_ready is always 0 outside IDLE.
- Data is passed through unchanged; no width change. Unknown fn codes and btaken gating are the ALU's job; the arbiter forwards them.
- alu_* outputs hold their last values after the operation and change only on a new grant.
- Requests arriving while busy are not dropped. The requester holds valid and the request is arbitrated on the next IDLE cycle.

## Timing
- Reset values: reqN_ready=0 (rst forces IDLE; ready is then valid-dependent), rspN_valid=0, rsp_result=0, rsp_btaken=0, all alu_*=0, busy=0, last_grant=1.
- Asynchronous reset at any point, including EXEC or RESP:
  - return to IDLE immediately and apply all reset values.
  - the in-flight operation is discarded; the requester must reissue.
- Latency: request accepted at edge k (valid&ready in cycle k-1). alu_* are valid from k. rspN_valid is high from edge k+1.
- Minimum issue spacing is 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready already high).
- Request handshake: transfer occurs at an edge where valid & ready. Requester must keep fn/operands stable while valid & !ready.
- Response handshake: transfer occurs at an edge where rsp_valid & rsp_ready. rsp_ready while rsp_valid=0 has no effect.
- Simultaneous requests always alternate; neither port can be starved for more than one operation.

## Test plan
- Single op: req0 fn=0000, opa=5, opb=7, rsp0_ready=1 -> req0_ready in IDLE cycle; rsp0_valid one cycle after EXEC; rsp_result=12, rsp_btaken=0; busy high for 2 cycles.
- Branch: req1 fn=1000, btype=1, bneq=1, opa=3, opb=3 -> rsp_result=0, rsp_btaken=0. Repeat with opb=4 -> rsp_btaken=1. rsp0_valid stays 0 throughout.
- Contention: req0 and req1 both held valid for 4 ops -> grant order 0,1,0,1. After reset the first tie goes to port 0.
- Backpressure: rsp0_ready=0 for 5 cycles after rsp0_valid -> rsp0_valid, rsp_result and FSM state held. A pending req1 is not accepted until a cycle after the rsp0 handshake.
- Reset mid-op: assert rst during EXEC of opa=1, opb=2 -> same cycle: rsp0_valid=0, busy=0, alu_opa=0. After release, a reissued op completes with rsp_result=3.
- Held request: req1 valid during port-0 RESP with operands changing is illegal. With operands stable, req1 is accepted in the first IDLE cycle and its own result is returned.
